square_arbiter: RTL and testbench
=================================

// Module: square_arbiter
// PURPOSE
//  Shares one iterative (shift-add) squaring engine among NREQ requesters.
//  A round-robin arbiter grants one requester at a time and latches its operand.
//  The engine computes operand*operand over W cycles and presents the result with its requester id.
//  The result is held under a valid/ready handshake.
//  Sits between operand producers and any consumer of din*din results.
// PARAMETERS
//  W     4  operand width; result width is 2*W
//  NREQ  4  number of requesters (>=2)
//  IDW   2  requester-id width, = clog2(NREQ)
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          synchronous reset, active-low
//  req         in   NREQ       per-requester request level
//  din         in   NREQ*W     operands; requester i at din[i*W +: W]
//  gnt         out  NREQ       one-hot, 1-cycle pulse: operand accepted
//  busy        out  1          1 whenever state != IDLE
//  dout        out  2*W        result = operand*operand, unsigned
//  dout_id     out  IDW        index of requester that owns dout
//  dout_valid  out  1          result available
//  dout_ready  in   1          consumer accepts result
// BEHAVIOUR
//  - Reset values (rst_n low at an edge): gnt=0, busy=0, dout=0, dout_id=0, dout_valid=0.
//    Reset also sets state=IDLE, accumulator=0, step count=0, and RR pointer last=NREQ-1.
//  - Reset mid-operation aborts the operation; its result is never presented.
//  - States: IDLE -> CALC -> DONE -> IDLE. All outputs are registered.
//  - IDLE: at an edge with req!=0, pick the first set req scanning last+1, last+2, ... (mod NREQ).
//    At that edge, for granted index g: latch op=din[g], last=g, dout_id=g, acc=0, cnt=0.
//    gnt[g]=1 for exactly one cycle; state=CALC. With req==0, stay in IDLE.
//  - CALC: each edge does acc += op[cnt] ? (op<<cnt) : 0, then cnt++. Arithmetic is 2*W wide, unsigned, no overflow.
//    After the W-th CALC edge: dout=final acc, dout_valid=1, state=DONE.
//  - Latency: dout_valid rises exactly W cycles after the gnt pulse.
//  - DONE: hold dout, dout_id and dout_valid stable while dout_ready=0.
//    At an edge with dout_ready=1: dout_valid=0, state=IDLE. dout keeps its last value.
//  - Throughput: with dout_ready tied high, one grant every W+2 cycles.
//  - No arbitration outside IDLE; req changes during CALC/DONE are ignored.
//  - Requester protocol: hold req and din stable until gnt.
//    req still high on the cycle after gnt counts as a new request.
//    req dropped before grant: no grant, no effect.
//  - Simultaneous requests: only the RR winner is granted; losers wait, not dropped.
//    A requester holding req is granted within NREQ operations.
//  - Edge operands: din=0 gives dout=0. din=2^W-1 gives (2^W-1)^2, e.g. 225 for W=4.
// TESTING  (W=4, NREQ=4)
//  1. After reset, req=0010, din[1]=13, ready=1 -> gnt=0010 for 1 cycle.
//     4 cycles later dout_valid=1, dout=169, dout_id=1; 1 cycle later busy=0.
//  2. Sweep din[0]=0..15 on req0 -> dout=0,1,4,...,225 in order, each with dout_id=0.
//  3. req=1111 held, ready=1 -> grant order 0,1,2,3,0,1.
//     Each gnt is W+2=6 cycles after the previous one.
//  4. Result pending with dout_ready=0 for 10 cycles, req=1111 -> dout_valid stays 1, dout stable, no gnt, busy=1.
//     Raise ready -> dout_valid drops, next gnt the following cycle.
//  5. rst_n=0 for 1 edge during CALC -> all outputs 0 and no dout_valid for the aborted op.
//     Then req=0101 -> gnt=0001.
//  6. req=0100 dropped 1 cycle before its would-be grant, while another op is in DONE
//     -> no gnt[2] ever issued for it.

Source files
------------

// File: rtl/square_arbiter.sv
// Round-robin front end for one shared shift-add squaring engine.
// One grant per operation; result held under valid/ready.
module square_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [2*W-1:0]    dout,
  output logic [IDW-1:0]    dout_id,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op_q, op_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [NREQ-1:0] gnt_d;
  logic [2*W-1:0]  dout_d;
  logic [IDW-1:0]  dout_id_d;
  logic            valid_d;
  logic            busy_d;

  logic            found;
  logic [IDW-1:0]  pick;
  logic [2*W-1:0]  pp;

  // scan starts just past the previous winner
  always_comb begin
    int k;
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_q) + i) % NREQ;
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = IDW'(k);
      end
    end
  end

  assign pp = {{W{1'b0}}, op_q} << cnt_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = '0;
    dout_d    = dout;
    dout_id_d = dout_id;
    valid_d   = dout_valid;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          op_d      = din[pick*W +: W];
          last_d    = pick;
          dout_id_d = pick;
          acc_d     = '0;
          cnt_d     = '0;
          gnt_d     = NREQ'(1) << pick;
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + (op_q[cnt_q] ? pp : '0);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          dout_d  = acc_d;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      last_q     <= IDW'(NREQ - 1);
      gnt        <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_id    <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt        <= gnt_d;
      busy       <= busy_d;
      dout       <= dout_d;
      dout_id    <= dout_id_d;
      dout_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_square_arbiter.sv
// Bench for square_arbiter: vector table, sweep and corner sequences.
// Expected results queue on drive, compared at the output handshake.
module tb_square_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [2*W-1:0]    dout;
  logic [IDW-1:0]    dout_id;
  logic              dout_valid;
  logic              dout_ready;

  square_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .busy(busy), .dout(dout), .dout_id(dout_id),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*W-1:0] val;
  } res_t;

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] din;
    int                id;
    int                val;
  } vec_t;

  res_t sb[$];
  vec_t tab[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_res(input int id, input int val);
    res_t r;
    r.id  = IDW'(id);
    r.val = (2*W)'(val);
    sb.push_back(r);
  endtask

  // handshake completes at the next rising edge
  always @(negedge clk) begin
    res_t e;
    if (rst_n && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("dout", int'(dout), int'(e.val));
        check("dout_id", int'(dout_id), int'(e.id));
      end
    end
  end

  task automatic wait_gnt(input string nm, input int exp_id);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (gnt == '0 && t < 20);
    check({nm, "_gnt"}, int'(gnt), 1 << exp_id);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (busy && t < 40);
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic run_op(input string nm, input logic [NREQ-1:0] r,
                        input logic [NREQ*W-1:0] d,
                        input int id, input int val);
    int n;
    expect_res(id, val);
    req = r;
    din = d;
    wait_gnt(nm, id);
    req = '0;
    tick();
    check({nm, "_pulse"}, int'(gnt), 0);
    n = 1;
    while (!dout_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_lat"}, n, W);
    tick();
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_vdrop"}, int'(dout_valid), 0);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    req   = '0;
    tick();
    check({nm, "_gnt"}, int'(gnt), 0);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_dout"}, int'(dout), 0);
    check({nm, "_id"}, int'(dout_id), 0);
    check({nm, "_valid"}, int'(dout_valid), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int prev;
    bit ok;
    logic [2*W-1:0] held;

    tab[0] = '{4'b0010, {4'd0, 4'd0, 4'd13, 4'd0}, 1, 169};
    tab[1] = '{4'b1111, {4'd9, 4'd7, 4'd5, 4'd3}, 2, 49};
    tab[2] = '{4'b1001, {4'd11, 4'd0, 4'd0, 4'd15}, 3, 121};
    tab[3] = '{4'b1010, {4'd2, 4'd0, 4'd0, 4'd0}, 1, 0};
    tab[4] = '{4'b0001, {4'd0, 4'd0, 4'd0, 4'd15}, 0, 225};
    tab[5] = '{4'b1100, {4'd4, 4'd6, 4'd0, 4'd0}, 2, 36};

    rst_n      = 1'b0;
    req        = '0;
    din        = '0;
    dout_ready = 1'b1;
    tick();
    do_reset("reset");

    for (int i = 0; i < 6; i++)
      run_op($sformatf("tab%0d", i), tab[i].req, tab[i].din,
             tab[i].id, tab[i].val);

    for (int i = 0; i < 16; i++)
      run_op($sformatf("sweep%0d", i), 4'b0001,
             {12'd0, 4'(i)}, 0, i * i);

    // all requesters held: rotation and W+2 spacing
    do_reset("reset3");
    din  = {4'd4, 4'd3, 4'd2, 4'd1};
    req  = 4'b1111;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      expect_res(k % 4, ((k % 4) + 1) * ((k % 4) + 1));
      wait_gnt($sformatf("rr%0d", k), k % 4);
      if (k > 0) check($sformatf("rr%0d_gap", k), cyc - prev, W + 2);
      prev = cyc;
    end
    req = '0;
    wait_idle("rr");

    // result stalled by the consumer
    dout_ready = 1'b0;
    req        = 4'b1111;
    expect_res(2, 9);
    wait_gnt("stall", 2);
    prev = 0;
    while (!dout_valid && prev < 20) begin
      tick();
      prev++;
    end
    check("stall_valid", int'(dout_valid), 1);
    held = dout;
    ok   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!dout_valid || dout != held || gnt != '0 || !busy) ok = 1'b0;
    end
    check("stall_hold", int'(ok), 1);
    expect_res(3, 16);
    dout_ready = 1'b1;
    tick();
    check("stall_vdrop", int'(dout_valid), 0);
    tick();
    check("stall_next_gnt", int'(gnt), 8);
    req = '0;
    wait_idle("stall");

    // reset in the middle of a calculation
    req = 4'b0010;
    din = {4'd0, 4'd0, 4'd6, 4'd0};
    wait_gnt("abort", 1);
    req = '0;
    tick();
    tick();
    do_reset("abort_rst");
    ok = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (dout_valid) ok = 1'b0;
    end
    check("abort_novalid", int'(ok), 1);
    run_op("post_abort", 4'b0101, {4'd0, 4'd7, 4'd0, 4'd5}, 0, 25);

    // request withdrawn just before it would win
    dout_ready = 1'b0;
    expect_res(0, 9);
    req = 4'b0001;
    din = {4'd0, 4'd5, 4'd0, 4'd3};
    wait_gnt("drop", 0);
    req  = '0;
    prev = 0;
    while (!dout_valid && prev < 20) begin
      tick();
      prev++;
    end
    check("drop_valid", int'(dout_valid), 1);
    req = 4'b0100;
    tick();
    tick();
    tick();
    dout_ready = 1'b1;
    tick();
    req = '0;
    ok  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt != '0) ok = 1'b0;
    end
    check("drop_nogrant", int'(ok), 1);
    check("drop_busy", int'(busy), 0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
